// File: rtl/fifo_sum_drain.sv
// Pops words from a show-ahead FIFO, sums the upper and lower halves of each word,
// and presents each sum through a valid/ready handshake.
// Accepted sums are accumulated into a running total and a saturating result count.
module fifo_sum_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   fifo_rdata,
  input  logic                    fifo_rempty,
  output logic                    fifo_rinc,
  output logic [DATA_WIDTH/2:0]   res_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACC_WIDTH-1:0]    acc,
  output logic [15:0]             count,
  output logic                    busy
);

  localparam int HALF  = DATA_WIDTH / 2;
  localparam int RES_W = HALF + 1;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   operand_q, operand_d;
  logic [RES_W-1:0]        res_data_q, res_data_d;
  logic                    res_valid_q, res_valid_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [15:0]             count_q, count_d;
  logic                    pop;
  logic                    handshake;

  // A pop can only coincide with an empty pipeline or with the result leaving OUT,
  // so at most one item is ever in flight.
  assign pop = enable && !fifo_rempty && !rst &&
               ((state_q == IDLE) || ((state_q == OUT) && res_ready));
  assign handshake = res_valid_q && res_ready;

  always_comb begin
    state_d     = state_q;
    operand_d   = operand_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    acc_d       = acc_q;
    count_d     = count_q;

    case (state_q)
      IDLE: begin
        if (pop) begin
          operand_d = fifo_rdata;
          state_d   = CALC;
        end
      end
      CALC: begin
        res_data_d  = {1'b0, operand_q[DATA_WIDTH-1:HALF]} + {1'b0, operand_q[HALF-1:0]};
        res_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (handshake) begin
          res_valid_d = 1'b0;
          if (pop) begin
            operand_d = fifo_rdata;
            state_d   = CALC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // clear wins over the accumulation of a simultaneously accepted result
    if (clear) begin
      acc_d   = '0;
      count_d = '0;
    end else if (handshake) begin
      acc_d   = acc_q + ACC_WIDTH'(res_data_q);
      count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      operand_q   <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      operand_q   <= operand_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
    end
  end

  assign fifo_rinc = pop;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign acc       = acc_q;
  assign count     = count_q;
  assign busy      = (state_q != IDLE) && !rst;

endmodule

// File: tb/tb_fifo_sum_drain.sv
// Directed self-checking bench for fifo_sum_drain with a small show-ahead FIFO model.
module tb_fifo_sum_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear;
  logic [31:0] fifo_rdata;
  logic        fifo_rempty;
  logic        fifo_rinc;
  logic [16:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic [39:0] acc;
  logic [15:0] count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  int          pop_count = 0;
  int          cyc = 0;
  int          pop_cyc [64];

  fifo_sum_drain #(.DATA_WIDTH(32), .ACC_WIDTH(40)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rinc(fifo_rinc),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .acc(acc), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  assign fifo_rempty = (rd_ptr == wr_ptr);
  assign fifo_rdata  = fifo_rempty ? 32'hDEADBEEF : mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rinc) begin
      rd_ptr    <= rd_ptr + 8'd1;
      pop_count <= pop_count + 1;
      if (pop_count < 64) pop_cyc[pop_count] <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 8'd1;
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; clear = 1'b0; res_ready = 1'b1;
    tick(); tick();
    push(32'h00050007);
    checks++; if (fifo_rinc !== 1'b0) begin errors++; $display("[TB] FAIL reset_rinc: got %0b expected 0", fifo_rinc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (res_valid !== 1'b0 || res_data !== 17'd0) begin errors++; $display("[TB] FAIL reset_res: got valid=%0b data=%0h expected 0/0", res_valid, res_data); end
    checks++; if (acc !== 40'd0 || count !== 16'd0) begin errors++; $display("[TB] FAIL reset_acc: got acc=%0h count=%0d expected 0/0", acc, count); end
  endtask

  task automatic test_basic_sum();
    int p0;
    p0 = pop_count;
    rst = 1'b0;
    #1;
    checks++; if (fifo_rinc !== 1'b1) begin errors++; $display("[TB] FAIL first_pop_rinc: got %0b expected 1", fifo_rinc); end
    tick();
    checks++; if (busy !== 1'b1 || res_valid !== 1'b0 || fifo_rinc !== 1'b0) begin errors++; $display("[TB] FAIL basic_calc: got busy=%0b valid=%0b rinc=%0b expected 1/0/0", busy, res_valid, fifo_rinc); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 17'd12) begin errors++; $display("[TB] FAIL basic_result: got valid=%0b data=%0d expected 1/12", res_valid, res_data); end
    tick();
    checks++; if (acc !== 40'd12 || count !== 16'd1 || res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_acc: got acc=%0d count=%0d valid=%0b busy=%0b expected 12/1/0/0", acc, count, res_valid, busy); end
    checks++; if (pop_count - p0 !== 1) begin errors++; $display("[TB] FAIL basic_pops: got %0d expected 1", pop_count - p0); end
  endtask

  task automatic test_carry();
    do_clear();
    checks++; if (acc !== 40'd0 || count !== 16'd0) begin errors++; $display("[TB] FAIL clear_idle: got acc=%0h count=%0d expected 0/0", acc, count); end
    push(32'hFFFFFFFF);
    tick(); tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 17'h1FFFE) begin errors++; $display("[TB] FAIL carry_result: got valid=%0b data=%0h expected 1/1fffe", res_valid, res_data); end
    tick();
    checks++; if (acc !== 40'h1FFFE || count !== 16'd1) begin errors++; $display("[TB] FAIL carry_acc: got acc=%0h count=%0d expected 1fffe/1", acc, count); end
  endtask

  task automatic test_backpressure();
    int p0;
    do_clear();
    res_ready = 1'b0;
    p0 = pop_count;
    push(32'h00010001); push(32'h00020003); push(32'h00040004);
    tick(); tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 17'd2) begin errors++; $display("[TB] FAIL bp_first: got valid=%0b data=%0d expected 1/2", res_valid, res_data); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (res_valid !== 1'b1 || res_data !== 17'd2 || fifo_rinc !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold%0d: got valid=%0b data=%0d rinc=%0b expected 1/2/0", i, res_valid, res_data, fifo_rinc); end
    end
    checks++; if (pop_count - p0 !== 1) begin errors++; $display("[TB] FAIL bp_single_pop: got %0d expected 1", pop_count - p0); end
    res_ready = 1'b1;
    tick();
    checks++; if (acc !== 40'd2 || res_valid !== 1'b0 || pop_count - p0 !== 2) begin errors++; $display("[TB] FAIL bp_release: got acc=%0d valid=%0b pops=%0d expected 2/0/2", acc, res_valid, pop_count - p0); end
    tick();
    checks++; if (res_data !== 17'd5 || res_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_second: got valid=%0b data=%0d expected 1/5", res_valid, res_data); end
    tick(); tick();
    checks++; if (res_data !== 17'd8 || res_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_third: got valid=%0b data=%0d expected 1/8", res_valid, res_data); end
    tick();
    checks++; if (acc !== 40'd15 || count !== 16'd3 || busy !== 1'b0 || pop_count - p0 !== 3) begin errors++; $display("[TB] FAIL bp_final: got acc=%0d count=%0d busy=%0b pops=%0d expected 15/3/0/3", acc, count, busy, pop_count - p0); end
    checks++; if (pop_cyc[p0+2] - pop_cyc[p0+1] !== 2) begin errors++; $display("[TB] FAIL bp_interval: got %0d expected 2", pop_cyc[p0+2] - pop_cyc[p0+1]); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_res [3];
    exp_res[0] = 17'd3; exp_res[1] = 17'd7; exp_res[2] = 17'd48;
    do_clear();
    push(32'h00010002); push(32'h00030004); push(32'h00100020);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (res_valid !== 1'b1 || res_data !== exp_res[i]) begin errors++; $display("[TB] FAIL b2b_res%0d: got valid=%0b data=%0d expected 1/%0d", i, res_valid, res_data, exp_res[i]); end
      tick();
    end
    checks++; if (acc !== 40'd58 || count !== 16'd3 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_acc: got acc=%0d count=%0d busy=%0b expected 58/3/0", acc, count, busy); end
  endtask

  task automatic test_clear_handshake();
    do_clear();
    push(32'h00050005);
    tick(); tick(); tick();
    checks++; if (acc !== 40'd10) begin errors++; $display("[TB] FAIL ch_pre: got acc=%0d expected 10", acc); end
    push(32'h00020002);
    tick(); tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 17'd4) begin errors++; $display("[TB] FAIL ch_result: got valid=%0b data=%0d expected 1/4", res_valid, res_data); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (acc !== 40'd0 || count !== 16'd0 || res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL ch_clear: got acc=%0d count=%0d valid=%0b busy=%0b expected 0/0/0/0", acc, count, res_valid, busy); end
    push(32'h00010001);
    tick(); tick(); tick();
    checks++; if (acc !== 40'd2 || count !== 16'd1) begin errors++; $display("[TB] FAIL ch_after: got acc=%0d count=%0d expected 2/1", acc, count); end
  endtask

  task automatic test_enable();
    int p0;
    do_clear();
    p0 = pop_count;
    enable = 1'b0;
    push(32'h00090001);
    tick(); tick();
    checks++; if (fifo_rinc !== 1'b0 || busy !== 1'b0 || pop_count !== p0) begin errors++; $display("[TB] FAIL en_block: got rinc=%0b busy=%0b pops=%0d expected 0/0/0", fifo_rinc, busy, pop_count - p0); end
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 17'd10) begin errors++; $display("[TB] FAIL en_inflight: got valid=%0b data=%0d expected 1/10", res_valid, res_data); end
    tick();
    checks++; if (acc !== 40'd10 || count !== 16'd1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL en_done: got acc=%0d count=%0d busy=%0b expected 10/1/0", acc, count, busy); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int p0;
    res_ready = 1'b0;
    push(32'h00030003);
    tick(); tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 17'd6) begin errors++; $display("[TB] FAIL rm_out: got valid=%0b data=%0d expected 1/6", res_valid, res_data); end
    push(32'h00070007);
    res_ready = 1'b1;
    rst = 1'b1;
    #1;
    p0 = pop_count;
    checks++; if (fifo_rinc !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rm_rst_comb: got rinc=%0b busy=%0b expected 0/0", fifo_rinc, busy); end
    tick();
    checks++; if (res_valid !== 1'b0 || res_data !== 17'd0 || acc !== 40'd0 || count !== 16'd0) begin errors++; $display("[TB] FAIL rm_state: got valid=%0b data=%0d acc=%0d count=%0d expected 0/0/0/0", res_valid, res_data, acc, count); end
    tick();
    checks++; if (pop_count !== p0 || fifo_rinc !== 1'b0) begin errors++; $display("[TB] FAIL rm_no_pop: got pops=%0d rinc=%0b expected 0/0", pop_count - p0, fifo_rinc); end
    rst = 1'b0;
    tick(); tick(); tick();
    checks++; if (acc !== 40'd14 || count !== 16'd1) begin errors++; $display("[TB] FAIL rm_recover: got acc=%0d count=%0d expected 14/1", acc, count); end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_carry();
    test_backpressure();
    test_back_to_back();
    test_clear_handshake();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
